// File: rtl/store_narrower_pkg.sv
// store_narrower_pkg
// Shared definitions for the store narrowing path: size encodings, byte
// strobe patterns, signed saturation limits and the pipeline stage payloads.
// No ports; imported by store_narrower and store_narrower_narrow_sat.
package store_narrower_pkg;

  // Access size encodings as they arrive on in_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Byte write strobe patterns, bit i enables byte lane i
  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_BYTE0   = 4'b0001;
  localparam logic [3:0] STRB_LO_HALF = 4'b0011;
  localparam logic [3:0] STRB_HI_HALF = 4'b1100;
  localparam logic [3:0] STRB_ALL     = 4'b1111;

  // Signed saturation limits for the narrow target sizes
  localparam logic [7:0]  BYTE_MAX = 8'h7F;
  localparam logic [7:0]  BYTE_MIN = 8'h80;
  localparam logic [15:0] HALF_MAX = 16'h7FFF;
  localparam logic [15:0] HALF_MIN = 16'h8000;

  // Raw beat captured by stage S1
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  size;
    logic [1:0]  addrLo;
    logic        sat;
  } s1Beat_t;

  // Finished store beat held by stage S2
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        ovf;
    logic        misalign;
  } s2Beat_t;

  // A half must sit on an even address, a word on a 4-byte boundary, and the
  // reserved size is never a legal access.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      SZ_WORD: bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_narrower_narrow_sat.sv
// store_narrower_narrow_sat
// Combinational narrowing of a 32-bit register value to a signed byte or half.
// Flags signed overflow and, when asked, clamps to the signed limits instead
// of truncating.
// Ports:
//   data_i   32  source register value
//   size_i    2  target size (byte / half / word / reserved)
//   sat_i     1  0 truncate, 1 saturate on overflow
//   value_o  16  narrowed value (byte result in [7:0], half in [15:0])
//   ovf_o     1  value does not fit the signed target size
module store_narrower_narrow_sat
  import store_narrower_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        sat_i,
  output logic [15:0] value_o,
  output logic        ovf_o
);

  logic byteOvf;
  logic halfOvf;

  // A value fits a signed N-bit target only when every bit from N-1 upward
  // is a copy of the sign, so anything other than all-ones or all-zeros in
  // that span is an overflow.
  always_comb begin
    byteOvf = !((&data_i[31:7]) || !(|data_i[31:7]));
    halfOvf = !((&data_i[31:15]) || !(|data_i[31:15]));
  end

  // Truncation is just the low bits; saturation picks the limit that matches
  // the sign of the original 32-bit value.
  always_comb begin
    value_o = data_i[15:0];
    ovf_o   = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        ovf_o = byteOvf;
        if (sat_i && byteOvf) begin
          value_o = {8'h00, (data_i[31] ? BYTE_MIN : BYTE_MAX)};
        end
      end
      SZ_HALF: begin
        ovf_o = halfOvf;
        if (sat_i && halfOvf) begin
          value_o = data_i[31] ? HALF_MIN : HALF_MAX;
        end
      end
      default: ovf_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_narrower.sv
// store_narrower
// Store-path narrower between register-file read and the data-memory write
// port. Narrows to byte/half with overflow detect and optional saturation,
// replicates the value across byte lanes and builds write strobes. Elastic
// two-stage pipeline (S1 inputs, S2 result) with valid/ready on both sides.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data[31:0]         source register value
//   in_size[1:0]          00 byte, 01 half, 10 word, 11 reserved
//   in_addr_lo[1:0]       byte address bits [1:0]
//   in_sat                0 truncate, 1 saturate
//   out_valid/out_ready   output handshake
//   out_data[31:0]        lane-replicated store data
//   out_strb[3:0]         byte write enables
//   out_ovf               value did not fit the signed target size
//   out_misalign          misaligned address or reserved size
//   ovf_clr               synchronous clear of ovf_count
//   ovf_count[CNT_W-1:0]  saturating count of delivered overflowed beats
module store_narrower
  import store_narrower_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_size,
  input  logic [1:0]       in_addr_lo,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_strb,
  output logic             out_ovf,
  output logic             out_misalign,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  logic             s1Valid_q;
  s1Beat_t          s1Beat_q;
  s1Beat_t          s1Beat_d;
  logic             s2Valid_q;
  s2Beat_t          s2Beat_q;
  s2Beat_t          s2Beat_d;
  logic             s2Load;
  logic             s1Load;
  logic [15:0]      narrowValue;
  logic             narrowOvf;
  logic             misalign;
  logic [CNT_W-1:0] ovfCount_q;
  logic [CNT_W-1:0] ovfCount_d;

  // S2 frees up whenever it is empty or its beat is being taken; S1 can then
  // refill in the same cycle, which gives full throughput without a bubble.
  always_comb begin
    s2Load   = !s2Valid_q || out_ready;
    s1Load   = !s1Valid_q || s2Load;
    in_ready = s1Load;
  end

  always_comb begin
    s1Beat_d.data   = in_data;
    s1Beat_d.size   = in_size;
    s1Beat_d.addrLo = in_addr_lo;
    s1Beat_d.sat    = in_sat;
  end

  store_narrower_narrow_sat uNarrowSat (
    .data_i  (s1Beat_q.data),
    .size_i  (s1Beat_q.size),
    .sat_i   (s1Beat_q.sat),
    .value_o (narrowValue),
    .ovf_o   (narrowOvf)
  );

  // Lane placement: the narrowed value is copied into every lane so memory
  // only needs the strobes to pick the right bytes. A misaligned or reserved
  // access writes nothing and reports no overflow; its data is don't-care.
  always_comb begin
    misalign          = isMisaligned(s1Beat_q.size, s1Beat_q.addrLo);
    s2Beat_d.data     = s1Beat_q.data;
    s2Beat_d.strb     = STRB_NONE;
    s2Beat_d.ovf      = narrowOvf;
    s2Beat_d.misalign = misalign;
    case (s1Beat_q.size)
      SZ_BYTE: begin
        s2Beat_d.data = {4{narrowValue[7:0]}};
        s2Beat_d.strb = STRB_BYTE0 << s1Beat_q.addrLo;
      end
      SZ_HALF: begin
        s2Beat_d.data = {2{narrowValue}};
        s2Beat_d.strb = s1Beat_q.addrLo[1] ? STRB_HI_HALF : STRB_LO_HALF;
      end
      SZ_WORD: begin
        s2Beat_d.data = s1Beat_q.data;
        s2Beat_d.strb = STRB_ALL;
      end
      default: begin
        s2Beat_d.data = s1Beat_q.data;
        s2Beat_d.strb = STRB_NONE;
      end
    endcase
    if (misalign) begin
      s2Beat_d.strb = STRB_NONE;
      s2Beat_d.ovf  = 1'b0;
    end
  end

  // Stage S1: payload only moves on a real beat so a drained stage keeps its
  // last contents instead of capturing idle bus values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Beat_q  <= '0;
    end else if (s1Load) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Beat_q <= s1Beat_d;
      end
    end
  end

  // Stage S2: holds every output field while a beat waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      s2Beat_q  <= '0;
    end else if (s2Load) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Beat_q <= s2Beat_d;
      end
    end
  end

  // Overflow event counter: counts delivered overflowed beats, sticks at
  // all-ones, and a clear in the same cycle as an increment wins.
  always_comb begin
    ovfCount_d = ovfCount_q;
    if (ovf_clr) begin
      ovfCount_d = '0;
    end else if (s2Valid_q && out_ready && s2Beat_q.ovf && !(&ovfCount_q)) begin
      ovfCount_d = ovfCount_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfCount_q <= '0;
    end else begin
      ovfCount_q <= ovfCount_d;
    end
  end

  always_comb begin
    out_valid    = s2Valid_q;
    out_data     = s2Beat_q.data;
    out_strb     = s2Beat_q.strb;
    out_ovf      = s2Beat_q.ovf;
    out_misalign = s2Beat_q.misalign;
    ovf_count    = ovfCount_q;
  end

endmodule

// File: tb/tb_store_narrower.sv
// tb_store_narrower
// Directed self-checking bench for store_narrower. A default-width instance
// carries the main checks; a second instance with CNT_W=2 shares its inputs
// to exercise counter saturation.
module tb_store_narrower;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic [1:0]  inSize;
  logic [1:0]  inAddrLo;
  logic        inSat;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [3:0]  outStrb;
  logic        outOvf;
  logic        outMisalign;
  logic        ovfClr;
  logic [15:0] ovfCount;

  logic        smallInReady;
  logic        smallOutValid;
  logic [31:0] smallOutData;
  logic [3:0]  smallOutStrb;
  logic        smallOutOvf;
  logic        smallOutMisalign;
  logic [1:0]  smallCount;

  int testsRun;
  int testsFailed;

  logic [31:0] capData;
  logic [3:0]  capStrb;
  logic        capOvf;
  logic        capMis;

  store_narrower dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (inValid),
    .in_ready     (inReady),
    .in_data      (inData),
    .in_size      (inSize),
    .in_addr_lo   (inAddrLo),
    .in_sat       (inSat),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_data     (outData),
    .out_strb     (outStrb),
    .out_ovf      (outOvf),
    .out_misalign (outMisalign),
    .ovf_clr      (ovfClr),
    .ovf_count    (ovfCount)
  );

  store_narrower #(.CNT_W(2)) dutSmall (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (inValid),
    .in_ready     (smallInReady),
    .in_data      (inData),
    .in_size      (inSize),
    .in_addr_lo   (inAddrLo),
    .in_sat       (inSat),
    .out_valid    (smallOutValid),
    .out_ready    (outReady),
    .out_data     (smallOutData),
    .out_strb     (smallOutStrb),
    .out_ovf      (smallOutOvf),
    .out_misalign (smallOutMisalign),
    .ovf_clr      (ovfClr),
    .ovf_count    (smallCount)
  );

  // Free-running 10 ns clock; the bench drives and samples on falling edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Put one beat on the input bus and raise valid.
  task automatic applyStimulus(input logic [31:0] data, input logic [1:0] size,
                               input logic [1:0] addrLo, input logic sat);
    inData   = data;
    inSize   = size;
    inAddrLo = addrLo;
    inSat    = sat;
    inValid  = 1'b1;
  endtask

  // Send one beat with out_ready high, check the two-cycle latency and
  // capture the delivered outputs. Optionally pulse ovf_clr in the same cycle
  // as the output handshake. Returns on the falling edge after the handshake.
  task automatic runBeat(input string tag, input logic [31:0] data, input logic [1:0] size,
                         input logic [1:0] addrLo, input logic sat, input logic clrAtOut);
    int waitCycles;
    applyStimulus(data, size, addrLo, sat);
    waitCycles = 0;
    while (!inReady && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 20) begin
      checkOutput({tag, "_inReadyTimeout"}, 32'(inReady), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput({tag, "_lat1"}, 32'(outValid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_lat2"}, 32'(outValid), 32'd1);
    capData = outData;
    capStrb = outStrb;
    capOvf  = outOvf;
    capMis  = outMisalign;
    ovfClr  = clrAtOut;
    @(negedge clk);
    ovfClr  = 1'b0;
  endtask

  initial begin
    logic [31:0] expStream [3];
    int received;
    logic acceptNow;

    testsRun    = 0;
    testsFailed = 0;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inSize   = '0;
    inAddrLo = '0;
    inSat    = 1'b0;
    outReady = 1'b1;
    ovfClr   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_outValid", 32'(outValid), 32'd0);
    checkOutput("rst_outData", outData, 32'h0);
    checkOutput("rst_outStrb", 32'(outStrb), 32'h0);
    checkOutput("rst_outOvf", 32'(outOvf), 32'd0);
    checkOutput("rst_outMis", 32'(outMisalign), 32'd0);
    checkOutput("rst_ovfCount", 32'(ovfCount), 32'd0);
    checkOutput("rst_inReady", 32'(inReady), 32'd1);
    checkOutput("rst_smallValid", 32'(smallOutValid), 32'd0);
    checkOutput("rst_smallBus", smallOutData | {27'd0, smallOutStrb, smallOutOvf}, 32'h0);
    checkOutput("rst_smallMisRdy", {30'd0, smallOutMisalign, smallInReady}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Half, negative value that fits, upper half lane
    runBeat("halfFit", 32'hFFFF_8000, 2'b01, 2'd2, 1'b0, 1'b0);
    checkOutput("halfFit_data", capData, 32'h8000_8000);
    checkOutput("halfFit_strb", 32'(capStrb), 32'hC);
    checkOutput("halfFit_ovf", 32'(capOvf), 32'd0);
    checkOutput("halfFit_mis", 32'(capMis), 32'd0);

    // Byte overflow, truncated, lane 3
    runBeat("byteTrunc", 32'h0000_0100, 2'b00, 2'd3, 1'b0, 1'b0);
    checkOutput("byteTrunc_data", capData, 32'h0000_0000);
    checkOutput("byteTrunc_strb", 32'(capStrb), 32'h8);
    checkOutput("byteTrunc_ovf", 32'(capOvf), 32'd1);
    checkOutput("byteTrunc_count", 32'(ovfCount), 32'd1);

    // Byte overflow, saturated positive
    runBeat("byteSat", 32'h0000_0100, 2'b00, 2'd3, 1'b1, 1'b0);
    checkOutput("byteSat_data", capData, 32'h7F7F_7F7F);
    checkOutput("byteSat_strb", 32'(capStrb), 32'h8);
    checkOutput("byteSat_ovf", 32'(capOvf), 32'd1);
    checkOutput("byteSat_count", 32'(ovfCount), 32'd2);

    // Word on a misaligned address
    runBeat("wordMis", 32'h1234_5678, 2'b10, 2'd1, 1'b0, 1'b0);
    checkOutput("wordMis_strb", 32'(capStrb), 32'h0);
    checkOutput("wordMis_mis", 32'(capMis), 32'd1);
    checkOutput("wordMis_ovf", 32'(capOvf), 32'd0);

    // Aligned word passes through untouched
    runBeat("wordOk", 32'hDEAD_BEEF, 2'b10, 2'd0, 1'b1, 1'b0);
    checkOutput("wordOk_data", capData, 32'hDEAD_BEEF);
    checkOutput("wordOk_strb", 32'(capStrb), 32'hF);
    checkOutput("wordOk_mis", 32'(capMis), 32'd0);

    // Reserved size
    runBeat("rsvd", 32'h0000_0001, 2'b11, 2'd0, 1'b0, 1'b0);
    checkOutput("rsvd_strb", 32'(capStrb), 32'h0);
    checkOutput("rsvd_mis", 32'(capMis), 32'd1);

    // Byte negative overflow saturates to 0x80, lane 0
    runBeat("byteNeg", 32'hFFFF_FF00, 2'b00, 2'd0, 1'b1, 1'b0);
    checkOutput("byteNeg_data", capData, 32'h8080_8080);
    checkOutput("byteNeg_strb", 32'(capStrb), 32'h1);
    checkOutput("byteNeg_ovf", 32'(capOvf), 32'd1);
    checkOutput("byteNeg_count", 32'(ovfCount), 32'd3);

    // Half positive overflow saturates to 0x7FFF, lower half
    runBeat("halfSat", 32'h0001_2345, 2'b01, 2'd0, 1'b1, 1'b0);
    checkOutput("halfSat_data", capData, 32'h7FFF_7FFF);
    checkOutput("halfSat_strb", 32'(capStrb), 32'h3);
    checkOutput("halfSat_ovf", 32'(capOvf), 32'd1);
    checkOutput("halfSat_count", 32'(ovfCount), 32'd4);
    checkOutput("halfSat_smallCount", 32'(smallCount), 32'd3);

    // Misaligned half suppresses overflow even though the value overflows
    runBeat("halfMis", 32'h0001_2345, 2'b01, 2'd1, 1'b0, 1'b0);
    checkOutput("halfMis_strb", 32'(capStrb), 32'h0);
    checkOutput("halfMis_ovf", 32'(capOvf), 32'd0);
    checkOutput("halfMis_mis", 32'(capMis), 32'd1);
    checkOutput("halfMis_count", 32'(ovfCount), 32'd4);

    // Standalone clear
    ovfClr = 1'b1;
    @(negedge clk);
    ovfClr = 1'b0;
    checkOutput("clr_count", 32'(ovfCount), 32'd0);
    checkOutput("clr_smallCount", 32'(smallCount), 32'd0);

    // Three overflows, then clear coincident with the fourth handshake
    for (int i = 0; i < 3; i++) begin
      runBeat("ovfRun", 32'h0000_0200, 2'b00, 2'd0, 1'b0, 1'b0);
    end
    checkOutput("ovf3_count", 32'(ovfCount), 32'd3);
    runBeat("ovfClr4", 32'h0000_0200, 2'b00, 2'd0, 1'b0, 1'b1);
    checkOutput("ovfClr4_count", 32'(ovfCount), 32'd0);

    // Five overflows: wide counter reaches 5, the 2-bit one sticks at 3
    for (int i = 0; i < 5; i++) begin
      runBeat("ovfSat", 32'h8000_0000, 2'b01, 2'd2, 1'b1, 1'b0);
    end
    checkOutput("ovf5_count", 32'(ovfCount), 32'd5);
    checkOutput("ovf5_smallCount", 32'(smallCount), 32'd3);
    checkOutput("ovf5_lastData", capData, 32'h8000_8000);

    // Back-to-back beats against a stalled sink
    expStream[0] = 32'h1111_1111;
    expStream[1] = 32'h2222_2222;
    expStream[2] = 32'h3333_3333;
    outReady = 1'b0;
    applyStimulus(32'h0000_0011, 2'b00, 2'd0, 1'b0);
    checkOutput("stall_rdyA", 32'(inReady), 32'd1);
    @(negedge clk);
    applyStimulus(32'h0000_0022, 2'b00, 2'd0, 1'b0);
    checkOutput("stall_rdyB", 32'(inReady), 32'd1);
    @(negedge clk);
    applyStimulus(32'h0000_0033, 2'b00, 2'd0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall_inReady", 32'(inReady), 32'd0);
      checkOutput("stall_outValid", 32'(outValid), 32'd1);
      checkOutput("stall_holdData", outData, 32'h1111_1111);
      checkOutput("stall_holdStrb", 32'(outStrb), 32'h1);
      @(negedge clk);
    end
    outReady = 1'b1;
    received = 0;
    for (int c = 0; c < 20 && received < 3; c++) begin
      if (outValid) begin
        checkOutput("drain_data", outData, expStream[received]);
        received++;
      end
      acceptNow = inValid && inReady;
      @(posedge clk);
      @(negedge clk);
      if (acceptNow) begin
        inValid = 1'b0;
      end
    end
    checkOutput("drain_received", 32'(received), 32'd3);
    repeat (2) @(negedge clk);
    checkOutput("drain_noDup", 32'(outValid), 32'd0);

    // Reset with two beats in flight
    outReady = 1'b0;
    applyStimulus(32'h0000_0400, 2'b00, 2'd1, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_0500, 2'b00, 2'd2, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("flight_outValid", 32'(outValid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("flightRst_outValid", 32'(outValid), 32'd0);
    checkOutput("flightRst_count", 32'(ovfCount), 32'd0);
    checkOutput("flightRst_strb", 32'(outStrb), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    runBeat("postRst", 32'h0000_007F, 2'b00, 2'd2, 1'b1, 1'b0);
    checkOutput("postRst_data", capData, 32'h7F7F_7F7F);
    checkOutput("postRst_strb", 32'(capStrb), 32'h4);
    checkOutput("postRst_ovf", 32'(capOvf), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("postRst_noGhost", 32'(outValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
